proc_fetch_queue: RTL and testbench

Instruction fetch stage for the TinyRV1 processor, directly upstream of the instruction port of the processor memory. Owns the PC, drives imemreq_val/imemreq_addr, captures the same-cycle combinational imemresp_data, and buffers {pc, inst} pairs in a small FIFO. The FIFO feeds decode over a val/rdy handshake, and the whole queue is flushed on a redirect from execute.

---
 rtl/proc_fetch_queue.sv | 119 +++++++++++
 tb/tb_proc_fetch_queue.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/proc_fetch_queue.sv
// TinyRV1 fetch stage: owns the PC, fetches from a combinational instruction memory
// and buffers {pc, inst} pairs for decode. Optional macro FETCH_BYPASS_EN adds a same-cycle empty-queue bypass.
module proc_fetch_queue #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int unsigned DEPTH      = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imemreq_val,
    output logic [31:0] imemreq_addr,
    input  logic [31:0] imemresp_data,
    input  logic        redirect_val,
    input  logic [31:0] redirect_target,
    output logic        inst_val,
    input  logic        inst_rdy,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } entry_t;

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [31:0]        pc_q, pc_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic head_val_c;
    logic deq_c;
    logic space_c;
    logic fetch_c;
    logic byp_c;
    logic enq_c;

    // Handshake terms; fetch is held off while reset is asserted even though count reads empty.
    always_comb begin
        head_val_c = (count_q != '0);
        deq_c      = head_val_c & inst_rdy;
        space_c    = (count_q < CNT_W'(DEPTH)) | ((count_q == CNT_W'(DEPTH)) & deq_c);
        fetch_c    = rst & space_c & ~redirect_val;
`ifdef FETCH_BYPASS_EN
        byp_c      = fetch_c & ~head_val_c;
`else
        byp_c      = 1'b0;
`endif
        // A bypassed word taken by decode this cycle never occupies a slot.
        enq_c      = fetch_c & ~(byp_c & inst_rdy);
    end

    always_comb begin
        imemreq_val  = fetch_c;
        imemreq_addr = pc_q;
        inst_val     = head_val_c | byp_c;
`ifdef FETCH_BYPASS_EN
        inst_data    = byp_c ? imemresp_data : mem_q[head_q].data;
        inst_pc      = byp_c ? pc_q          : mem_q[head_q].pc;
`else
        inst_data    = mem_q[head_q].data;
        inst_pc      = mem_q[head_q].pc;
`endif
    end

    // Next-state: redirect flushes everything and wins over fetch/deq.
    always_comb begin
        pc_d    = pc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        mem_d   = mem_q;
        if (redirect_val) begin
            pc_d    = redirect_target & ~32'd3;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (deq_c) begin
                head_d = head_q + PTR_W'(1);
            end
            if (fetch_c) begin
                pc_d = pc_q + 32'd4;
            end
            if (enq_c) begin
                mem_d[tail_q] = '{pc: pc_q, data: imemresp_data};
                tail_d        = tail_q + PTR_W'(1);
            end
            case ({enq_c, deq_c})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q    <= RESET_ADDR;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            pc_q    <= pc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

endmodule

// File: tb/tb_proc_fetch_queue.sv
// Bench for proc_fetch_queue: queue-level reference model checked every cycle plus directed literal checks.
module tb_proc_fetch_queue;

    localparam int unsigned DEPTH = 2;
`ifdef FETCH_BYPASS_EN
    localparam int LAT = 0;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imemreq_val;
    logic [31:0] imemreq_addr;
    logic [31:0] imemresp_data;
    logic        redirect_val = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        inst_val;
    logic        inst_rdy = 1'b0;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_pc = 32'h0;
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] s_addr, s_pc, s_data;
    logic        s_mval, s_ival;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   mem_word = 32'h7c30_1073;
            32'h4:   mem_word = 32'hfc20_20f3;
            32'h8:   mem_word = 32'hfc40_2173;
            default: mem_word = {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
        endcase
    endfunction

    assign imemresp_data = mem_word(imemreq_addr);

    proc_fetch_queue #(.RESET_ADDR(32'h0), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .imemreq_val     (imemreq_val),
        .imemreq_addr    (imemreq_addr),
        .imemresp_data   (imemresp_data),
        .redirect_val    (redirect_val),
        .redirect_target (redirect_target),
        .inst_val        (inst_val),
        .inst_rdy        (inst_rdy),
        .inst_data       (inst_data),
        .inst_pc         (inst_pc)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a falling edge: drive inputs, compare with the model, advance the model, move to next falling edge.
    task automatic step(input logic rdy, input logic rv, input logic [31:0] tgt);
        int   n;
        logic hv, dq, sp, ft, byp;
        inst_rdy        = rdy;
        redirect_val    = rv;
        redirect_target = tgt;
        #1;
        s_addr = imemreq_addr;
        s_mval = imemreq_val;
        s_ival = inst_val;
        s_pc   = inst_pc;
        s_data = inst_data;
        n   = q.size();
        hv  = (n != 0);
        dq  = hv && rdy;
        sp  = (n < int'(DEPTH)) || (n == int'(DEPTH) && dq);
        ft  = sp && !rv;
        byp = 1'b0;
`ifdef FETCH_BYPASS_EN
        byp = ft && !hv;
`endif
        chk("imemreq_val", 32'(s_mval), 32'(ft));
        chk("imemreq_addr", s_addr, m_pc);
        chk("inst_val", 32'(s_ival), 32'(hv || byp));
        if (hv) begin
            chk("inst_pc", s_pc, q[0].pc);
            chk("inst_data", s_data, q[0].data);
        end else if (byp) begin
            chk("inst_pc_byp", s_pc, m_pc);
            chk("inst_data_byp", s_data, mem_word(m_pc));
        end
        if (rv) begin
            q.delete();
            m_pc = {tgt[31:2], 2'b00};
        end else begin
            if (dq) void'(q.pop_front());
            if (ft) begin
                if (!(byp && rdy)) q.push_back('{pc: m_pc, data: mem_word(m_pc)});
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst          = 1'b0;
        inst_rdy     = 1'b0;
        redirect_val = 1'b0;
        q.delete();
        m_pc = 32'h0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_imemreq_val", 32'(imemreq_val), 32'h0);
        chk("rst_inst_val", 32'(inst_val), 32'h0);
        chk("rst_addr", imemreq_addr, 32'h0);
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pcs [6];
        logic [31:0] dat [6];
        logic [31:0] adr [6];
        @(negedge clk);

        // S1: free-running fetch with decode always ready.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 32'h0);
            adr[i] = s_addr;
            pcs[i] = s_pc;
            dat[i] = s_data;
        end
        chk("s1_addr0", adr[0], 32'h0);
        chk("s1_addr1", adr[1], 32'h4);
        chk("s1_addr2", adr[2], 32'h8);
        chk("s1_pc0", pcs[LAT], 32'h0);
        chk("s1_data0", dat[LAT], 32'h7c30_1073);
        chk("s1_pc1", pcs[LAT+1], 32'h4);
        chk("s1_data1", dat[LAT+1], 32'hfc20_20f3);
        chk("s1_data2", dat[LAT+2], 32'hfc40_2173);

        // S2: decode stalled from reset, then released.
        do_reset();
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 32'h0);
        chk("s2_stall_mval", 32'(s_mval), 32'h0);
        chk("s2_stall_addr", s_addr, 32'h8);
        chk("s2_stall_head", s_pc, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 32'h0);
            pcs[i] = s_pc;
            adr[i] = 32'(s_mval);
        end
        chk("s2_drain0", pcs[0], 32'h0);
        chk("s2_drain1", pcs[1], 32'h4);
        chk("s2_drain2", pcs[2], 32'h8);
        chk("s2_refetch", adr[0], 32'h1);

        // S3: redirect while full and decode ready.
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h26);
        chk("s3_redir_mval", 32'(s_mval), 32'h0);
        step(1'b1, 1'b0, 32'h0);
        chk("s3_addr", s_addr, 32'h24);
`ifndef FETCH_BYPASS_EN
        chk("s3_empty", 32'(s_ival), 32'h0);
        step(1'b1, 1'b0, 32'h0);
`endif
        chk("s3_pc", s_pc, 32'h24);

        // S4: redirect held across three cycles.
        step(1'b1, 1'b1, 32'h10);
        chk("s4_hold0", 32'(s_mval), 32'h0);
        step(1'b1, 1'b1, 32'h20);
        chk("s4_hold1", 32'(s_mval), 32'h0);
        step(1'b1, 1'b1, 32'h30);
        chk("s4_hold2", 32'(s_mval), 32'h0);
        step(1'b1, 1'b0, 32'h0);
        chk("s4_first", s_addr, 32'h30);

        // S5: PC wrap past the top of the address space.
        step(1'b1, 1'b1, 32'hFFFF_FFF8);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 32'h0);
            adr[i] = s_addr;
            pcs[i] = s_pc;
        end
        chk("s5_a0", adr[0], 32'hFFFF_FFF8);
        chk("s5_a1", adr[1], 32'hFFFF_FFFC);
        chk("s5_a2", adr[2], 32'h0000_0000);
        chk("s5_p0", pcs[LAT], 32'hFFFF_FFF8);
        chk("s5_p2", pcs[LAT+2], 32'h0000_0000);

        // Mixed traffic against the model.
        for (int i = 0; i < 150; i++) begin
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0), $urandom);
        end

        // S6: asynchronous reset mid-cycle with a full queue.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0);
        inst_rdy = 1'b1;
        #1;
        chk("s6_pre_full", 32'(inst_val), 32'h1);
        rst = 1'b0;
        #1;
        chk("s6_async_ival", 32'(inst_val), 32'h0);
        chk("s6_async_mval", 32'(imemreq_val), 32'h0);
        q.delete();
        m_pc = 32'h0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, 1'b0, 32'h0);
        chk("s6_first_addr", s_addr, 32'h0);
        chk("s6_first_mval", 32'(s_mval), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
